// File: rtl/spi_slave_byte_link_pkg.sv
// Shared types and widths for the SPI peripheral-side byte link.
package spi_slave_byte_link_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } link_state_e;
endpackage

// File: rtl/spi_slave_byte_link_if.sv
// Controller-side byte bus between the main control block (master) and the SPI link (slave).
interface spi_slave_byte_link_if;
  import spi_slave_byte_link_pkg::*;

  logic [BYTE_W-1:0] byte_to_spi;
  logic              spi_start;
  logic [BYTE_W-1:0] byte_from_spi;
  logic              spi_input_valid;
  logic              spi_busy;
  logic              tx_underrun;
  logic              frame_error;

  modport master (
    output byte_to_spi, spi_start,
    input  byte_from_spi, spi_input_valid, spi_busy, tx_underrun, frame_error
  );

  modport slave (
    input  byte_to_spi, spi_start,
    output byte_from_spi, spi_input_valid, spi_busy, tx_underrun, frame_error
  );
endinterface

// File: rtl/spi_slave_byte_link_input_sync.sv
// N-stage synchroniser for an asynchronous SPI pin with edge strobes taken from the last two stages.
module spi_slave_byte_link_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);
  // chain[0] is the newest sample, chain[STAGES-1] the settled one
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= {STAGES{RESET_VAL}};
    else        chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_out = chain[STAGES-1];
  assign rise     =  chain[STAGES-2] & ~chain[STAGES-1];
  assign fall     = ~chain[STAGES-2] &  chain[STAGES-1];
endmodule

// File: rtl/spi_slave_byte_link.sv
// SPI mode-0 peripheral byte transceiver: oversampled SCLK/CS_n/MOSI, bytes out with a 1-cycle valid,
// TX byte from a holding register shifted onto MISO (IDLE_FILL with an underrun pulse when none pending).
module spi_slave_byte_link
  import spi_slave_byte_link_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_FILL   = 8'h00
) (
  input  logic sysClk,
  input  logic sysRst_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  spi_slave_byte_link_if.slave ctl
);
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_slave_byte_link_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(sysClk), .rst_n(sysRst_n), .async_in(spi_sclk),
    .sync_out(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_slave_byte_link_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(sysClk), .rst_n(sysRst_n), .async_in(spi_cs_n),
    .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );
  spi_slave_byte_link_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sysClk), .rst_n(sysRst_n), .async_in(spi_mosi),
    .sync_out(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  link_state_e       state, state_nxt;
  logic [BYTE_W-1:0] tx_shift, tx_nxt;
  logic [BYTE_W-1:0] rx_shift, rx_nxt;
  logic [BYTE_W-1:0] tx_hold, hold_nxt;
  logic [BYTE_W-1:0] rx_byte, rx_byte_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt, cnt_inc;
  logic              tx_pending, pending_nxt;
  logic              valid_q, valid_nxt;
  logic              underrun_q, underrun_nxt;
  logic              ferr_q, ferr_nxt;
  logic              miso_q, miso_nxt;
  logic              load;
  logic [BYTE_W-1:0] load_byte;

  assign cnt_inc = bit_cnt + 4'd1;

  always_comb begin
    state_nxt    = state;
    tx_nxt       = tx_shift;
    rx_nxt       = rx_shift;
    hold_nxt     = tx_hold;
    rx_byte_nxt  = rx_byte;
    cnt_nxt      = bit_cnt;
    pending_nxt  = tx_pending;
    valid_nxt    = 1'b0;
    underrun_nxt = 1'b0;
    ferr_nxt     = 1'b0;
    miso_nxt     = miso_q;
    load         = 1'b0;
    load_byte    = IDLE_FILL;

    if (ctl.spi_start) begin
      hold_nxt    = ctl.byte_to_spi;
      pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        // CS release takes priority over any SCLK edge seen in the same cycle
        if (cs_rise) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ferr_nxt  = (bit_cnt != '0);
        end else if (sclk_rise) begin
          rx_nxt = {rx_shift[BYTE_W-2:0], mosi_sync};
          if (cnt_inc == 4'd8) begin
            cnt_nxt     = '0;
            rx_byte_nxt = {rx_shift[BYTE_W-2:0], mosi_sync};
            valid_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else if (sclk_fall) begin
          if (bit_cnt != '0) begin
            tx_nxt   = {tx_shift[BYTE_W-2:0], 1'b0};
            miso_nxt = tx_shift[BYTE_W-2];
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A start strobe coinciding with a load supplies the loaded byte directly
    if (load) begin
      if (ctl.spi_start)   load_byte = ctl.byte_to_spi;
      else if (tx_pending) load_byte = tx_hold;
      else                 underrun_nxt = 1'b1;
      tx_nxt      = load_byte;
      miso_nxt    = load_byte[BYTE_W-1];
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst_n) begin
      state      <= IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      tx_hold    <= '0;
      rx_byte    <= '0;
      bit_cnt    <= '0;
      tx_pending <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      ferr_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_shift   <= tx_nxt;
      rx_shift   <= rx_nxt;
      tx_hold    <= hold_nxt;
      rx_byte    <= rx_byte_nxt;
      bit_cnt    <= cnt_nxt;
      tx_pending <= pending_nxt;
      valid_q    <= valid_nxt;
      underrun_q <= underrun_nxt;
      ferr_q     <= ferr_nxt;
      miso_q     <= miso_nxt;
    end
  end

  assign spi_miso            = miso_q;
  assign spi_miso_oe         = ~cs_sync;
  assign ctl.spi_busy        = ~cs_sync;
  assign ctl.byte_from_spi   = rx_byte;
  assign ctl.spi_input_valid = valid_q;
  assign ctl.tx_underrun     = underrun_q;
  assign ctl.frame_error     = ferr_q;
endmodule

// File: tb/tb_spi_slave_byte_link.sv
// Bench: emulated SPI host driving mode-0 frames, queue-based reference model and a decoupled output monitor.
module tb_spi_slave_byte_link;
  typedef logic [7:0] u8_t;

  logic sysClk = 1'b0;
  logic sysRst_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_slave_byte_link_if bus();

  spi_slave_byte_link #(.SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .ctl(bus)
  );

  always #5 sysClk = ~sysClk;

  int vectors = 0, miscompares = 0;
  u8_t exp_rx[$], exp_miso[$];
  int exp_valid = 0, obs_valid = 0, exp_underrun = 0, obs_underrun = 0, exp_ferr = 0, obs_ferr = 0;
  logic model_pending = 1'b0;
  u8_t model_hold = 8'h00, model_last_rx = 8'h00;
  int half = 5;
  u8_t fd[$];
  u8_t md[16];
  logic [15:0] mid_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic start_byte(input u8_t b);
    bus.byte_to_spi = b;
    bus.spi_start   = 1'b1;
    model_hold      = b;
    model_pending   = 1'b1;
    tick(1);
    bus.spi_start   = 1'b0;
  endtask

  // The host expects a fresh byte on MISO whenever a byte slot begins
  task automatic model_load();
    if (model_pending) exp_miso.push_back(model_hold);
    else begin
      exp_miso.push_back(8'h00);
      exp_underrun++;
    end
    model_pending = 1'b0;
  endtask

  task automatic reset_checks();
    check("reset_byte_miso_oe_busy", {bus.byte_from_spi, spi_miso, spi_miso_oe, bus.spi_busy}, 32'h0);
    check("reset_pulses", {bus.spi_input_valid, bus.tx_underrun, bus.frame_error}, 32'h0);
  endtask

  // Sends nbits of fd[] MSB first; the final SCLK fall coincides with CS release
  task automatic run_frame(input int nbits, input bit rst_abort);
    u8_t cur;
    spi_cs_n = 1'b0;
    model_load();
    cur = fd[0];
    spi_mosi = cur[7];
    tick(half);
    check("busy_oe_in_frame", {bus.spi_busy, spi_miso_oe}, 32'h3);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      if (i % 8 == 7) begin
        exp_rx.push_back(fd[i/8]);
        exp_valid++;
        model_last_rx = fd[i/8];
      end
      if (i % 8 == 7 && i != nbits - 1 && mid_en[i/8]) begin
        tick(3);
        start_byte(md[i/8]);
        tick(half - 4);
      end else begin
        tick(half);
      end
      spi_sclk = 1'b0;
      if (i == nbits - 1) begin
        spi_cs_n = 1'b1;
        if (rst_abort) begin
          sysRst_n = 1'b0;
          model_pending = 1'b0;
          model_hold = 8'h00;
          model_last_rx = 8'h00;
          tick(1);
          reset_checks();
          sysRst_n = 1'b1;
        end else if (nbits % 8 != 0) begin
          exp_ferr++;
        end
      end else begin
        cur = fd[(i+1)/8];
        spi_mosi = cur[7 - ((i+1) % 8)];
        if (i % 8 == 7) model_load();
      end
      tick(half);
    end
  endtask

  task automatic frame_checks();
    tick(8);
    check("valid_count", obs_valid, exp_valid);
    check("underrun_count", obs_underrun, exp_underrun);
    check("frame_error_count", obs_ferr, exp_ferr);
    check("byte_from_spi_held", bus.byte_from_spi, model_last_rx);
    check("busy_oe_idle", {bus.spi_busy, spi_miso_oe}, 32'h0);
    check("queues_drained", exp_rx.size() + exp_miso.size(), 0);
  endtask

  // Monitor: received bytes, pulse counts, and MISO as sampled by the host on SCLK rise
  logic prev_valid = 1'b0, prev_sclk = 1'b0, prev_cs = 1'b1;
  u8_t miso_acc = 8'h00;
  int miso_n = 0;
  always @(negedge sysClk) begin
    if (spi_sclk && !prev_sclk && !spi_cs_n) begin
      miso_acc = {miso_acc[6:0], spi_miso};
      miso_n++;
      if (miso_n == 8) begin
        miso_n = 0;
        if (exp_miso.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL miso_unexpected: got byte %h, required none", miso_acc);
        end else check("miso_byte", miso_acc, exp_miso.pop_front());
      end
    end
    if (spi_cs_n && !prev_cs) begin
      if (miso_n != 0 && exp_miso.size() != 0) void'(exp_miso.pop_front());
      miso_n = 0;
    end
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
    if (bus.spi_input_valid) begin
      obs_valid++;
      check("valid_single_cycle", prev_valid, 0);
      if (exp_rx.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rx_unexpected: got valid with byte %h, required no valid", bus.byte_from_spi);
      end else check("rx_byte", bus.byte_from_spi, exp_rx.pop_front());
    end
    prev_valid = bus.spi_input_valid;
    if (bus.tx_underrun) obs_underrun++;
    if (bus.frame_error) obs_ferr++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbytes, nbits;
    bus.byte_to_spi = 8'h00;
    bus.spi_start   = 1'b0;
    mid_en = '0;
    tick(3);
    reset_checks();
    sysRst_n = 1'b1;
    tick(4);

    // Single byte: A5 out, 3C in
    start_byte(8'hA5);
    fd = {}; fd.push_back(8'h3C);
    run_frame(8, 1'b0);
    frame_checks();

    // Three bytes, second TX byte supplied after the first valid, third underruns
    start_byte(8'h11);
    fd = {}; fd.push_back(8'h33); fd.push_back(8'h44); fd.push_back(8'h55);
    mid_en = 16'h0001; md[0] = 8'h22;
    run_frame(24, 1'b0);
    mid_en = '0;
    frame_checks();

    // Last write wins
    start_byte(8'h55);
    tick(2);
    start_byte(8'hAA);
    fd = {}; fd.push_back(8'h12);
    run_frame(8, 1'b0);
    frame_checks();

    // Partial byte then a clean frame
    fd = {}; fd.push_back(8'hF0);
    run_frame(5, 1'b0);
    frame_checks();
    fd = {}; fd.push_back(8'h81);
    run_frame(8, 1'b0);
    frame_checks();

    // Reset after bit 4, then a fresh frame
    fd = {}; fd.push_back(8'h99);
    run_frame(4, 1'b1);
    frame_checks();
    fd = {}; fd.push_back(8'h7E);
    run_frame(8, 1'b0);
    frame_checks();

    // SCLK at exactly sysClk/4, 16 back-to-back bytes
    half = 2;
    fd = {};
    for (int k = 0; k < 16; k++) fd.push_back(8'(k + 8'h40));
    start_byte(8'hC3);
    run_frame(128, 1'b0);
    frame_checks();
    half = 5;

    // Random frames: lengths, partial tails, pre-frame and mid-frame TX writes
    for (int f = 0; f < 20; f++) begin
      nbytes = $urandom_range(1, 4);
      fd = {};
      for (int k = 0; k < nbytes; k++) fd.push_back(8'($urandom));
      nbits = ($urandom_range(0, 4) == 0) ? 8*(nbytes-1) + $urandom_range(1, 7) : 8*nbytes;
      if ($urandom_range(0, 1) == 1) start_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) start_byte(8'($urandom));
      mid_en = 16'($urandom);
      for (int k = 0; k < 16; k++) md[k] = 8'($urandom);
      run_frame(nbits, 1'b0);
      frame_checks();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
